// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: WM8731 power-up register sequencer driving an i2c serialiser; optional CODEC_CFG_VOLUME_EN adds headphone volume updates from DONE
module codec_cfg_sequencer #(
  parameter logic [7:0]  DEV_ADDR  = 8'h34,
  parameter logic [15:0] TIMEOUT   = 16'd50000,
  parameter int unsigned MAX_RETRY = 2,
  parameter logic [15:0] GAP_CYC   = 16'd1000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  output logic [23:0] i2c_data_o,
  output logic        i2c_go_o,
  input  logic        i2c_end_i,
  input  logic        i2c_nack_i,
`ifdef CODEC_CFG_VOLUME_EN
  input  logic        vol_wr_i,
  input  logic [6:0]  vol_val_i,
`endif
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [3:0]  idx_o
);
  typedef enum logic [3:0] {IDLE, LOAD, SEND, WAIT, CHECK, RETRY, GAP, DONE, ERR} state_t;
  localparam logic [3:0] LAST = 4'd10;
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d, rcnt_q, rcnt_d;
  logic [15:0] tcnt_q, tcnt_d, entry;
  logic [23:0] data_q, data_d;
  logic nack_q, vol_q, vol_d, vstep_q, vstep_d;
  logic [6:0] vval_q, vval_d;
  // The table holds the codec reset word followed by ten configuration registers, as {reg_addr, reg_val}.
  function automatic logic [15:0] tbl(input logic [3:0] i);
    case (i)
      4'd0:    tbl = {7'h0F, 9'h000};
      4'd1:    tbl = {7'h00, 9'h017};
      4'd2:    tbl = {7'h01, 9'h017};
      4'd3:    tbl = {7'h02, 9'h079};
      4'd4:    tbl = {7'h03, 9'h079};
      4'd5:    tbl = {7'h04, 9'h012};
      4'd6:    tbl = {7'h05, 9'h000};
      4'd7:    tbl = {7'h06, 9'h000};
      4'd8:    tbl = {7'h07, 9'h00A};
      4'd9:    tbl = {7'h08, 9'h000};
      default: tbl = {7'h09, 9'h001};
    endcase
  endfunction
  assign entry = vol_q ? {vstep_q ? 7'h03 : 7'h02, 2'b01, vval_q} : tbl(idx_q);
  // Next-state logic; tcnt restarts on every state change, so it times SEND, WAIT and GAP separately.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rcnt_d  = rcnt_q;
    data_d  = data_q;
    vol_d   = vol_q;
    vstep_d = vstep_q;
    vval_d  = vval_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d = LOAD;
          idx_d   = '0;
          rcnt_d  = '0;
          vol_d   = 1'b0;
        end
`ifdef CODEC_CFG_VOLUME_EN
        else if (state_q == DONE && vol_wr_i) begin
          state_d = LOAD;
          rcnt_d  = '0;
          vol_d   = 1'b1;
          vstep_d = 1'b0;
          vval_d  = vol_val_i;
        end
`endif
      end
      LOAD: begin
        data_d  = {DEV_ADDR, entry};
        state_d = SEND;
      end
      SEND:  state_d = !i2c_end_i ? WAIT : (tcnt_q == TIMEOUT - 16'd1) ? RETRY : SEND;
      WAIT:  state_d = i2c_end_i ? CHECK : (tcnt_q == TIMEOUT - 16'd1) ? RETRY : WAIT;
      CHECK: begin
        if (nack_q) state_d = RETRY;
        else if (vol_q ? vstep_q : idx_q == LAST) state_d = DONE;
        else begin
          state_d = GAP;
          rcnt_d  = '0;
          vstep_d = vol_q;
          idx_d   = vol_q ? idx_q : idx_q + 4'd1;
        end
      end
      RETRY: begin
        state_d = (rcnt_q == 4'(MAX_RETRY)) ? ERR : GAP;
        rcnt_d  = (rcnt_q == 4'(MAX_RETRY)) ? rcnt_q : rcnt_q + 4'd1;
      end
      GAP:     state_d = (tcnt_q == GAP_CYC - 16'd1) ? LOAD : GAP;
      default: state_d = IDLE;
    endcase
    tcnt_d = (state_d != state_q) ? '0 : tcnt_q + 16'd1;
  end
  // State registers; NACK is captured on the cycle the serialiser reports completion.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
      data_q  <= '0;
      nack_q  <= 1'b0;
      vol_q   <= 1'b0;
      vstep_q <= 1'b0;
      vval_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rcnt_q  <= rcnt_d;
      tcnt_q  <= tcnt_d;
      data_q  <= data_d;
      nack_q  <= (state_q == WAIT && i2c_end_i) ? i2c_nack_i : nack_q;
      vol_q   <= vol_d;
      vstep_q <= vstep_d;
      vval_q  <= vval_d;
    end
  end
  assign i2c_data_o = data_q;
  assign i2c_go_o   = state_q == SEND || state_q == WAIT;
  assign busy_o     = !(state_q == IDLE || state_q == DONE || state_q == ERR);
  assign done_o     = state_q == DONE;
  assign error_o    = state_q == ERR;
  assign idx_o      = idx_q;
endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// tb_codec_cfg_sequencer: directed checks of the codec sequencer against a scripted serialiser responder
module tb_codec_cfg_sequencer;
  logic clk = 0, reset = 1, start = 0, end_i = 1, nack = 0;
  logic [23:0] data;
  logic go, busy, done, error;
  logic [3:0] idx;
`ifdef CODEC_CFG_VOLUME_EN
  logic vol_wr = 0;
  logic [6:0] vol_val = '0;
`endif
  int checks = 0, errors = 0;
  int writes = 0, t = 0, nacks_left = 0;
  bit armed = 1, accept = 1, unstable = 0;
  logic [23:0] nack_word = '0, cur = '0;
  logic [23:0] wlog[$];
  always #5 clk = ~clk;
  codec_cfg_sequencer #(.TIMEOUT(16'd100), .GAP_CYC(16'd100)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .i2c_data_o(data), .i2c_go_o(go), .i2c_end_i(end_i), .i2c_nack_i(nack),
`ifdef CODEC_CFG_VOLUME_EN
    .vol_wr_i(vol_wr), .vol_val_i(vol_val),
`endif
    .busy_o(busy), .done_o(done), .error_o(error), .idx_o(idx)
  );
  // Serialiser stand-in: accepts 3 cycles after go, completes 20 cycles later.
  always @(posedge clk) begin
    #1;
    if (!go) begin
      armed = 1;
      end_i = 1;
      nack = 0;
    end else if (armed) begin
      armed = 0;
      t = 0;
      writes++;
      cur = data;
      wlog.push_back(data);
    end else begin
      t++;
      if (data != cur) unstable = 1;
      if (t == 3 && accept) end_i = 0;
      if (t == 23 && accept) begin
        end_i = 1;
        nack = (data == nack_word && nacks_left > 0);
        if (nack) nacks_left--;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1;
    cyc();
    start = 0;
  endtask
  task automatic clear_log();
    writes = 0;
    unstable = 0;
    wlog.delete();
  endtask
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20000 && busy; i++) cyc();
    chk(tag, busy, 0);
  endtask
  initial begin
    int n;
    repeat (3) cyc();
    reset = 0;
    chk("rst_go", go, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_idx", idx, 0);
    cyc();
    clear_log();
    pulse_start();
    chk("lat1_go", go, 0);
    chk("lat1_busy", busy, 1);
    cyc();
    chk("lat2_go", go, 1);
    chk("lat2_data", data, 24'h341E00);
    repeat (300) cyc();
    pulse_start();
    wait_idle("run1_idle");
    chk("run1_writes", writes, 11);
    chk("run1_first", wlog[0], 24'h341E00);
    chk("run1_entry3", wlog[3], 24'h340479);
    chk("run1_last", wlog[10], 24'h341201);
    chk("run1_done", done, 1);
    chk("run1_error", error, 0);
    chk("run1_stable", unstable, 0);
    clear_log();
    nack_word = 24'h340812;
    nacks_left = 1;
    pulse_start();
    wait_idle("nack_idle");
    n = 0;
    foreach (wlog[i]) if (wlog[i] == 24'h340812) n++;
    chk("nack_writes", writes, 12);
    chk("nack_resend", n, 2);
    chk("nack_done", done, 1);
    chk("nack_error", error, 0);
    clear_log();
    accept = 0;
    pulse_start();
    wait_idle("to_idle");
    chk("to_writes", writes, 3);
    chk("to_error", error, 1);
    chk("to_done", done, 0);
    chk("to_idx", idx, 0);
    chk("to_go", go, 0);
    accept = 1;
    clear_log();
    pulse_start();
    for (int i = 0; i < 20000 && !(go && idx == 5); i++) cyc();
    chk("mid_reach", go && idx == 5, 1);
    repeat (8) cyc();
    chk("mid_wait_go", go, 1);
    reset = 1;
    cyc();
    chk("mid_go", go, 0);
    chk("mid_busy", busy, 0);
    chk("mid_idx", idx, 0);
    chk("mid_error", error, 0);
    reset = 0;
    cyc();
    clear_log();
    pulse_start();
    cyc();
    chk("restart_data", data, 24'h341E00);
    chk("restart_idx", idx, 0);
    wait_idle("restart_idle");
    chk("restart_writes", writes, 11);
    chk("restart_done", done, 1);
`ifdef CODEC_CFG_VOLUME_EN
    clear_log();
    vol_val = 7'h60;
    vol_wr = 1;
    cyc();
    vol_wr = 0;
    chk("vol_busy", busy, 1);
    chk("vol_done_low", done, 0);
    wait_idle("vol_idle");
    chk("vol_writes", writes, 2);
    chk("vol_first", wlog[0], 24'h3404E0);
    chk("vol_second", wlog[1], 24'h3406E0);
    chk("vol_done", done, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
